// File: rtl/mc_ctrl_pipe.sv
// Four-stage microcode control-word pipeline: carries the decoded word from stage 0 to 3,
// inserts bubbles on RAW hazards, honours global stall and branch flush, counts retirements.
module mc_ctrl_pipe #(
   parameter int unsigned WIDTH = 25,
   parameter int unsigned REG_W = 5,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_mc,
   input  logic [REG_W-1:0] in_rs1,
   input  logic [REG_W-1:0] in_rs2,
   input  logic [REG_W-1:0] in_rd,
   input  logic             stall,
   input  logic             flush,
   output logic             s0_valid,
   output logic [WIDTH-1:0] s0_mc,
   output logic             s1_valid,
   output logic [WIDTH-1:0] s1_mc,
   output logic             s2_valid,
   output logic [WIDTH-1:0] s2_mc,
   output logic             s3_valid,
   output logic [WIDTH-1:0] s3_mc,
   output logic [REG_W-1:0] s3_rd,
   output logic             hazard,
   output logic [CNT_W-1:0] retired
);

   localparam int unsigned REG_WE_BIT  = 22;
   localparam int unsigned CHK_RS1_BIT = 0;
   localparam int unsigned CHK_RS2_BIT = 1;

   logic             s0_valid_q, s0_valid_d;
   logic [WIDTH-1:0] s0_mc_q,    s0_mc_d;
   logic [REG_W-1:0] s0_rd_q,    s0_rd_d;
   logic [REG_W-1:0] s0_rs1_q,   s0_rs1_d;
   logic [REG_W-1:0] s0_rs2_q,   s0_rs2_d;
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_mc_q,    s1_mc_d;
   logic [REG_W-1:0] s1_rd_q,    s1_rd_d;
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] s2_mc_q,    s2_mc_d;
   logic [REG_W-1:0] s2_rd_q,    s2_rd_d;
   logic             s3_valid_q, s3_valid_d;
   logic [WIDTH-1:0] s3_mc_q,    s3_mc_d;
   logic [REG_W-1:0] s3_rd_q,    s3_rd_d;
   logic [CNT_W-1:0] retired_q,  retired_d;

   logic rs1_hit, rs2_hit;
   logic rs1_dep, rs2_dep;
   logic hazard_w;
   logic in_ready_w;
   logic accept;

   // Stage 3 is not checked: the regfile writes through to same-cycle reads.
   always_comb begin
      rs1_hit = (s1_valid_q & s1_mc_q[REG_WE_BIT] & (s1_rd_q == s0_rs1_q)) |
                (s2_valid_q & s2_mc_q[REG_WE_BIT] & (s2_rd_q == s0_rs1_q));
      rs2_hit = (s1_valid_q & s1_mc_q[REG_WE_BIT] & (s1_rd_q == s0_rs2_q)) |
                (s2_valid_q & s2_mc_q[REG_WE_BIT] & (s2_rd_q == s0_rs2_q));
      rs1_dep = s0_mc_q[CHK_RS1_BIT] & (s0_rs1_q != '0) & rs1_hit;
      rs2_dep = s0_mc_q[CHK_RS2_BIT] & (s0_rs2_q != '0) & rs2_hit;
      hazard_w   = s0_valid_q & (rs1_dep | rs2_dep);
      in_ready_w = !rst & !stall & !flush & (!s0_valid_q | !hazard_w);
      accept     = in_valid & in_ready_w;
   end

   always_comb begin
      s0_valid_d = s0_valid_q;
      s0_mc_d    = s0_mc_q;
      s0_rd_d    = s0_rd_q;
      s0_rs1_d   = s0_rs1_q;
      s0_rs2_d   = s0_rs2_q;
      s1_valid_d = s1_valid_q;
      s1_mc_d    = s1_mc_q;
      s1_rd_d    = s1_rd_q;
      s2_valid_d = s2_valid_q;
      s2_mc_d    = s2_mc_q;
      s2_rd_d    = s2_rd_q;
      s3_valid_d = s3_valid_q;
      s3_mc_d    = s3_mc_q;
      s3_rd_d    = s3_rd_q;
      retired_d  = retired_q;

      if (!stall) begin
         retired_d  = retired_q + {{(CNT_W-1){1'b0}}, s3_valid_q};
         s3_valid_d = s2_valid_q;
         s3_mc_d    = s2_mc_q;
         s3_rd_d    = s2_rd_q;

         // A flush kills s0/s1 and does not forward s1 into s2; the branch in s2 still retires.
         if (flush) begin
            s2_valid_d = 1'b0;
            s2_mc_d    = '0;
            s2_rd_d    = '0;
            s1_valid_d = 1'b0;
            s1_mc_d    = '0;
            s1_rd_d    = '0;
            s0_valid_d = 1'b0;
            s0_mc_d    = '0;
            s0_rd_d    = '0;
            s0_rs1_d   = '0;
            s0_rs2_d   = '0;
         end else begin
            s2_valid_d = s1_valid_q;
            s2_mc_d    = s1_mc_q;
            s2_rd_d    = s1_rd_q;
            if (hazard_w) begin
               s1_valid_d = 1'b0;
               s1_mc_d    = '0;
               s1_rd_d    = '0;
            end else begin
               s1_valid_d = s0_valid_q;
               s1_mc_d    = s0_mc_q;
               s1_rd_d    = s0_rd_q;
               if (accept) begin
                  s0_valid_d = 1'b1;
                  s0_mc_d    = in_mc;
                  s0_rd_d    = in_rd;
                  s0_rs1_d   = in_rs1;
                  s0_rs2_d   = in_rs2;
               end else begin
                  s0_valid_d = 1'b0;
                  s0_mc_d    = '0;
                  s0_rd_d    = '0;
                  s0_rs1_d   = '0;
                  s0_rs2_d   = '0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s0_valid_q <= 1'b0;
         s0_mc_q    <= '0;
         s0_rd_q    <= '0;
         s0_rs1_q   <= '0;
         s0_rs2_q   <= '0;
         s1_valid_q <= 1'b0;
         s1_mc_q    <= '0;
         s1_rd_q    <= '0;
         s2_valid_q <= 1'b0;
         s2_mc_q    <= '0;
         s2_rd_q    <= '0;
         s3_valid_q <= 1'b0;
         s3_mc_q    <= '0;
         s3_rd_q    <= '0;
         retired_q  <= '0;
      end else begin
         s0_valid_q <= s0_valid_d;
         s0_mc_q    <= s0_mc_d;
         s0_rd_q    <= s0_rd_d;
         s0_rs1_q   <= s0_rs1_d;
         s0_rs2_q   <= s0_rs2_d;
         s1_valid_q <= s1_valid_d;
         s1_mc_q    <= s1_mc_d;
         s1_rd_q    <= s1_rd_d;
         s2_valid_q <= s2_valid_d;
         s2_mc_q    <= s2_mc_d;
         s2_rd_q    <= s2_rd_d;
         s3_valid_q <= s3_valid_d;
         s3_mc_q    <= s3_mc_d;
         s3_rd_q    <= s3_rd_d;
         retired_q  <= retired_d;
      end
   end

   assign in_ready = in_ready_w;
   assign hazard   = hazard_w;
   assign s0_valid = s0_valid_q;
   assign s0_mc    = s0_mc_q;
   assign s1_valid = s1_valid_q;
   assign s1_mc    = s1_mc_q;
   assign s2_valid = s2_valid_q;
   assign s2_mc    = s2_mc_q;
   assign s3_valid = s3_valid_q;
   assign s3_mc    = s3_mc_q;
   assign s3_rd    = s3_rd_q;
   assign retired  = retired_q;

endmodule
